// File: rtl/button_pulse_bank_pkg.sv
// Shared definitions for the push-button pulse bank: FSM encoding and counter sizing.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    HELD    = 2'b10
  } btn_state_e;

  // Bits needed to hold values 0..max_val-1; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_pulse_bank_if.sv
// Button bank bus: raw button levels in, debounced level and event pulses out.
interface button_pulse_bank_if #(
  parameter int N_CH = 4
);
  import btn_pkg::*;

  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;

  // Board side: drives the raw buttons, consumes the events.
  modport master (
    output btn_in,
    input  level, press, release_pulse, repeat_pulse
  );

  // Pulse bank side.
  modport slave (
    input  btn_in,
    output level, press, release_pulse, repeat_pulse
  );
endinterface

// File: rtl/button_pulse_bank_channel.sv
// One button channel: 2-flop synchroniser, debouncer and press/hold/release FSM.
module button_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = cnt_width(HMAX);

  localparam logic [DW-1:0] D_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
  localparam logic [HW-1:0] H_SAT     = '1;

  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          level_q, level_d;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;

  logic          accept;
  logic          rise;
  logic          fall;
  logic [HW-1:0] hcnt_inc;

  // Synchroniser shift and debounce: a level change is accepted after
  // DEBOUNCE_CYCLES consecutive disagreeing synchronised samples.
  always_comb begin
    sync_d  = {sync_q[0], btn_in};
    dcnt_d  = '0;
    level_d = level_q;
    accept  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (dcnt_q == D_LAST) begin
        level_d = ~level_q;
        accept  = 1'b1;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  assign rise     = accept & ~level_q;
  assign fall     = accept &  level_q;
  assign hcnt_inc = (hcnt_q == H_SAT) ? hcnt_q : hcnt_q + 1'b1;

  // Event FSM: press on accepted rise, release on accepted fall (which wins
  // over a coincident repeat), repeat pulses while held when enabled.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
          hcnt_d    = '0;
        end else if (REPEAT_EN && (hcnt_q == HOLD_LAST)) begin
          repeat_d = 1'b1;
          state_d  = HELD;
          hcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_inc;
        end
      end
      HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
          hcnt_d    = '0;
        end else if (hcnt_q == REP_LAST) begin
          repeat_d = 1'b1;
          hcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      state_q   <= IDLE;
      hcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/button_pulse_bank.sv
// Bank of N_CH independent debounced push-button channels.
module button_pulse_bank
  import btn_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input logic               clk,
  input logic               rst,
  button_pulse_bank_if.slave bus
);

  logic [N_CH-1:0] level_w;
  logic [N_CH-1:0] press_w;
  logic [N_CH-1:0] release_w;
  logic [N_CH-1:0] repeat_w;

  // One fully independent channel per button.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .REPEAT_EN      (REPEAT_EN)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (bus.btn_in[gi]),
      .level        (level_w[gi]),
      .press        (press_w[gi]),
      .release_pulse(release_w[gi]),
      .repeat_pulse (repeat_w[gi])
    );
  end

  assign bus.level         = level_w;
  assign bus.press         = press_w;
  assign bus.release_pulse = release_w;
  assign bus.repeat_pulse  = repeat_w;

endmodule
